// File: rtl/obi_spi_master_mc.sv
// obi_spi_master_mc: OBI-slave SPI master with a TX FIFO, several chip selects
// and an OLED data/command line.
//   clk_i, rst_i           : clock, synchronous active-high reset
//   req_i/we_i/be_i/addr_i : OBI request (be_i ignored, addr_i[3:2] decoded)
//   wdata_i/aid_i          : write data, transaction id
//   gnt_o                  : grant (always equals req_i)
//   rvalid_o/rdata_o       : response, one cycle after each request
//   rid_o/err_o            : response id and error flag
//   sck_o/mosi_o/cs_no     : SPI clock, data (MSB first), active-low selects
//   dc_o                   : data/command bit of the current byte
//   irq_o                  : one-cycle pulse when the FIFO drains and the engine idles
// Registers: 0 TXDATA (W), 1 CTRL (R/W), 2 STATUS (R), 3 invalid.
module obi_spi_master_mc #(
  parameter int NumCs     = 2,
  parameter int FifoDepth = 8,
  parameter int IdWidth   = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req_i,
  input  logic               we_i,
  input  logic [3:0]         be_i,
  input  logic [31:0]        addr_i,
  input  logic [31:0]        wdata_i,
  input  logic [IdWidth-1:0] aid_i,
  output logic               gnt_o,
  output logic               rvalid_o,
  output logic [31:0]        rdata_o,
  output logic [IdWidth-1:0] rid_o,
  output logic               err_o,
  output logic               sck_o,
  output logic               mosi_o,
  output logic [NumCs-1:0]   cs_no,
  output logic               dc_o,
  output logic               irq_o
);
  localparam int AW = $clog2(FifoDepth);
  localparam int LW = AW + 1;
  localparam logic [31:0] CtrlMask = 32'h0001_37FF;

  typedef enum logic [1:0] {IDLE, LEAD, XFER, TRAIL} state_e;
  state_e state_q;

  logic [31:0]        ctrl_q;
  logic [9:0]         mem_q [FifoDepth];
  logic [AW-1:0]      wptr_q, rptr_q;
  logic [LW-1:0]      level_q;
  logic               empty, full, busy, push, pop, hp_done, load_cpha, ctrl_wr;
  logic [9:0]         head;
  logic [NumCs-1:0]   cs_dec;

  logic [7:0]         div_q, cnt_q, sh_q;
  logic [3:0]         tog_q;
  logic               cpol_q, cpha_q, rel_q, sck_q, mosi_q, dc_q, irq_q;
  logic [NumCs-1:0]   cs_q;

  logic               rvalid_q, err_q, err_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [IdWidth-1:0] rid_q;
  logic               unused_ok;

  assign empty     = (level_q == '0);
  assign full      = (level_q == LW'(FifoDepth));
  assign busy      = (state_q != IDLE);
  assign head      = mem_q[rptr_q];
  assign hp_done   = (cnt_q == div_q);
  assign load_cpha = (state_q == IDLE) ? ctrl_q[13] : cpha_q;
  assign unused_ok = ^{be_i, addr_i[31:4], addr_i[1:0]};

  // Pops happen only at byte boundaries: leaving IDLE or at the end of TRAIL.
  always_comb begin
    pop = 1'b0;
    unique case (state_q)
      IDLE:    pop = ctrl_q[16] && !empty;
      TRAIL:   pop = hp_done && !rel_q && ctrl_q[16] && !empty;
      default: pop = 1'b0;
    endcase
  end

  always_comb begin
    cs_dec = '1;
    for (int unsigned i = 0; i < NumCs; i++)
      if (ctrl_q[10:8] == 3'(i)) cs_dec[i] = 1'b0;
  end

  // Register decode; a write to a full FIFO is accepted only if a pop frees a slot.
  always_comb begin
    push    = 1'b0;
    ctrl_wr = 1'b0;
    err_d   = 1'b0;
    rdata_d = '0;
    if (req_i) begin
      unique case (addr_i[3:2])
        2'd0: if (we_i) begin
                if (full && !pop) err_d = 1'b1;
                else              push  = 1'b1;
              end
        2'd1: if (we_i) ctrl_wr = 1'b1;
              else      rdata_d = ctrl_q;
        2'd2: if (we_i) err_d = 1'b1;
              else      rdata_d = {21'b0, busy, full, empty, 1'b0, 7'(level_q)};
        default: err_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      rid_q    <= '0;
      ctrl_q   <= '0;
    end else begin
      rvalid_q <= req_i;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      if (req_i)   rid_q  <= aid_i;
      if (ctrl_wr) ctrl_q <= wdata_i & CtrlMask;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (push) begin
        mem_q[wptr_q] <= wdata_i[9:0];
        wptr_q        <= wptr_q + AW'(1);
      end
      if (pop) rptr_q <= rptr_q + AW'(1);
      if (push && !pop)      level_q <= level_q + LW'(1);
      else if (pop && !push) level_q <= level_q - LW'(1);
    end
  end

  // cpha=0 preloads bit 7 onto mosi at pop and shifts on trailing edges;
  // cpha=1 keeps the whole byte in the shifter and shifts on leading edges.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
      tog_q   <= '0;
      sh_q    <= '0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      rel_q   <= 1'b0;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      dc_q    <= 1'b0;
      cs_q    <= '1;
      irq_q   <= 1'b0;
    end else begin
      irq_q <= 1'b0;
      if (pop) begin
        dc_q  <= head[8];
        rel_q <= head[9];
        if (load_cpha) sh_q <= head[7:0];
        else begin
          mosi_q <= head[7];
          sh_q   <= {head[6:0], 1'b0};
        end
      end
      unique case (state_q)
        IDLE: begin
          sck_q <= ctrl_q[12];
          cnt_q <= '0;
          if (pop) begin
            state_q <= LEAD;
            div_q   <= ctrl_q[7:0];
            cpol_q  <= ctrl_q[12];
            cpha_q  <= ctrl_q[13];
            cs_q    <= cs_dec;
          end
        end
        LEAD: begin
          sck_q <= cpol_q;
          if (hp_done) begin
            state_q <= XFER;
            cnt_q   <= '0;
            tog_q   <= '0;
          end else cnt_q <= cnt_q + 8'd1;
        end
        XFER: begin
          if (hp_done) begin
            cnt_q <= '0;
            sck_q <= ~sck_q;
            tog_q <= tog_q + 4'd1;
            if (cpha_q ? !tog_q[0] : (tog_q[0] && tog_q != 4'd15)) begin
              mosi_q <= sh_q[7];
              sh_q   <= {sh_q[6:0], 1'b0};
            end
            if (tog_q == 4'd15) state_q <= TRAIL;
          end else cnt_q <= cnt_q + 8'd1;
        end
        TRAIL: begin
          // cnt_q parks at div_q so a CS-held wait keeps hp_done asserted.
          if (!hp_done) cnt_q <= cnt_q + 8'd1;
          else if (pop) begin
            state_q <= XFER;
            cnt_q   <= '0;
            tog_q   <= '0;
          end else if (rel_q || !ctrl_q[16]) begin
            state_q <= IDLE;
            cs_q    <= '1;
            irq_q   <= empty && !push;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt_o    = req_i;
  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign rid_o    = rid_q;
  assign err_o    = err_q;
  assign sck_o    = sck_q;
  assign mosi_o   = mosi_q;
  assign cs_no    = cs_q;
  assign dc_o     = dc_q;
  assign irq_o    = irq_q;
endmodule

// File: tb/tb_obi_spi_master_mc.sv
// Bench for obi_spi_master_mc: directed OBI accesses with expected responses,
// an SPI line monitor that rebuilds bytes from the mode's sampling edges, and
// literal checks on edge counts, CS assertions and reset behaviour.
module tb_obi_spi_master_mc;
  localparam int NumCs = 2;
  localparam int FifoDepth = 8;
  localparam int IdWidth = 1;

  logic clk = 1'b0;
  logic rst, req, we;
  logic [3:0] be;
  logic [31:0] addr, wdata;
  logic [IdWidth-1:0] aid;
  logic gnt_o, rvalid_o, err_o, sck_o, mosi_o, dc_o, irq_o;
  logic [31:0] rdata_o;
  logic [IdWidth-1:0] rid_o;
  logic [NumCs-1:0] cs_no;

  obi_spi_master_mc #(.NumCs(NumCs), .FifoDepth(FifoDepth), .IdWidth(IdWidth)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .be_i(be), .addr_i(addr),
    .wdata_i(wdata), .aid_i(aid), .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .rid_o(rid_o), .err_o(err_o), .sck_o(sck_o), .mosi_o(mosi_o), .cs_no(cs_no),
    .dc_o(dc_o), .irq_o(irq_o));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s (event missing)", name);
  endtask

  // ---------------- OBI response model ----------------
  typedef struct { bit err; logic [IdWidth-1:0] id; logic [31:0] rd; } resp_t;
  resp_t rq[$];
  resp_t r;
  logic req_seen = 1'b0;

  always @(posedge clk) req_seen <= req && !rst;

  always @(negedge clk) begin
    if (!rst) begin
      chk("GNT", gnt_o, req);
      chk("RVALID", rvalid_o, req_seen);
      if (req_seen) begin
        if (rq.size() == 0) fail("RESP_UNEXPECTED");
        else begin
          r = rq.pop_front();
          chk("RID", rid_o, r.id);
          chk("ERR", err_o, r.err);
          chk("RDATA", rdata_o, r.rd);
        end
      end else chk("ERR_IDLE", err_o, 0);
    end
  end

  task automatic bus(input bit w, input logic [31:0] a, input logic [31:0] d,
                     input logic [IdWidth-1:0] id, input bit eerr, input logic [31:0] erd);
    @(posedge clk); #1;
    req = 1'b1; we = w; addr = a; wdata = d; aid = id; be = 4'hF;
    rq.push_back('{err: eerr, id: id, rd: erd});
    @(posedge clk); #1;
    req = 1'b0; we = 1'b0;
  endtask

  // ---------------- SPI line monitor ----------------
  typedef struct { logic [7:0] d; bit dc; } byte_t;
  byte_t bq[$];
  byte_t b;
  bit mon_en, m_cpol, m_cpha;
  int m_div;
  logic [NumCs-1:0] exp_cs, prev_cs = '1;
  logic prev_sck = 1'b0;
  logic [7:0] rx = '0, last_rx = '0;
  int since = 0, edges = 0, nbits = 0, rises = 0, cs_falls = 0, last_int = 0;

  always @(negedge clk) begin
    if (rst || !mon_en) begin
      prev_sck = sck_o; nbits = 0; edges = 0; since = 0;
    end else begin
      since++;
      if (sck_o !== prev_sck) begin
        if (edges != 0) chk("HALF_PERIOD", since, m_div + 1);
        last_int = since;
        since = 0;
        edges++;
        if (sck_o) rises++;
        // sample on leading edges for cpha=0, trailing edges for cpha=1
        if ((prev_sck == m_cpol) != m_cpha) begin
          rx = {rx[6:0], mosi_o};
          nbits++;
          chk("CS_DURING_BYTE", cs_no, exp_cs);
          if (bq.size() > 0) chk("DC", dc_o, bq[0].dc);
          if (nbits == 8) begin
            if (bq.size() == 0) fail("SPI_UNEXPECTED_BYTE");
            else begin
              b = bq.pop_front();
              chk("SPI_BYTE", rx, b.d);
            end
            last_rx = rx;
            nbits = 0;
          end
        end
        if (edges == 16) edges = 0;
      end
      prev_sck = sck_o;
    end
    if (!rst && prev_cs == '1 && cs_no != '1) cs_falls++;
    prev_cs = cs_no;
  end

  task automatic setup(input logic [31:0] ctrl, input logic [NumCs-1:0] ecs);
    mon_en = 1'b0;
    m_cpol = ctrl[12];
    m_cpha = ctrl[13];
    m_div  = int'(ctrl[7:0]);
    exp_cs = ecs;
    bus(1'b1, 32'h4, ctrl, '0, 1'b0, 32'h0);
    repeat (3) @(negedge clk);
    chk("IDLE_SCK", sck_o, m_cpol);
    mon_en = 1'b1;
  endtask

  task automatic wait_irq(input int maxc);
    int n = 0;
    while (irq_o !== 1'b1 && n < maxc) begin
      @(negedge clk);
      n++;
    end
    if (irq_o !== 1'b1) fail("IRQ_TIMEOUT");
    else begin
      @(negedge clk);
      chk("IRQ_PULSE_WIDTH", irq_o, 0);
    end
    chk("BYTES_LEFT", bq.size(), 0);
    chk("CS_RELEASED", cs_no, 2'b11);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  int r0, c0, n;

  initial begin
    rst = 1'b1; req = 1'b0; we = 1'b0; be = '0; addr = '0; wdata = '0; aid = '0;
    mon_en = 1'b0; m_cpol = 1'b0; m_cpha = 1'b0; m_div = 0; exp_cs = '1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("RST_CS", cs_no, 2'b11);
    chk("RST_SCK", sck_o, 0);
    chk("RST_MOSI", mosi_o, 0);
    chk("RST_DC", dc_o, 0);
    chk("RST_IRQ", irq_o, 0);
    chk("RST_RVALID", rvalid_o, 0);

    // register map and error responses
    bus(1'b0, 32'hC, 32'h0, 1'b1, 1'b1, 32'h0);
    bus(1'b0, 32'h8, 32'h0, 1'b0, 1'b0, 32'h100);
    bus(1'b1, 32'h8, 32'hFFFF, 1'b1, 1'b1, 32'h0);
    bus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    bus(1'b1, 32'h4, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0);
    bus(1'b0, 32'h4, 32'h0, 1'b1, 1'b0, 32'h0001_37FF);
    bus(1'b1, 32'h4, 32'h0, 1'b0, 1'b0, 32'h0);

    // fill FIFO with engine disabled; ninth write overflows
    for (int i = 0; i < 9; i++)
      bus(1'b1, 32'h0, 32'h200 | i, i[0], (i == 8), 32'h0);
    bus(1'b0, 32'h8, 32'h0, 1'b0, 1'b0, 32'h208);
    do_reset();
    bus(1'b0, 32'h8, 32'h0, 1'b0, 1'b0, 32'h100);
    bus(1'b0, 32'h4, 32'h0, 1'b0, 1'b0, 32'h0);

    // mode 0, div 3, cs0, single released byte
    setup(32'h0001_0003, 2'b10);
    r0 = rises; c0 = cs_falls;
    bq.push_back('{d: 8'hA5, dc: 1'b0});
    bus(1'b1, 32'h0, 32'h2A5, 1'b0, 1'b0, 32'h0);
    wait_irq(400);
    chk("A5_RISES", rises - r0, 8);
    chk("A5_CS_ASSERTS", cs_falls - c0, 1);
    chk("A5_LAST_BYTE", last_rx, 8'hA5);
    chk("A5_HALF_PERIOD", last_int, 4);

    // two bytes, CS held; first waits in TRAIL for the second push
    c0 = cs_falls;
    bq.push_back('{d: 8'h11, dc: 1'b1});
    bus(1'b1, 32'h0, 32'h111, 1'b0, 1'b0, 32'h0);
    repeat (150) @(negedge clk);
    chk("HOLD_CS_LOW", cs_no, 2'b10);
    chk("HOLD_LAST_BYTE", last_rx, 8'h11);
    bus(1'b0, 32'h8, 32'h0, 1'b0, 1'b0, 32'h500);
    bq.push_back('{d: 8'hF0, dc: 1'b0});
    bus(1'b1, 32'h0, 32'h2F0, 1'b0, 1'b0, 32'h0);
    wait_irq(400);
    chk("PAIR_CS_ASSERTS", cs_falls - c0, 1);
    chk("PAIR_LAST_BYTE", last_rx, 8'hF0);

    // mode 3, div 1, cs1, dc=1
    setup(32'h0001_3101, 2'b01);
    bq.push_back('{d: 8'h3C, dc: 1'b1});
    bus(1'b1, 32'h0, 32'h33C, 1'b0, 1'b0, 32'h0);
    wait_irq(300);
    chk("M3_LAST_BYTE", last_rx, 8'h3C);
    chk("M3_SCK_IDLE", sck_o, 1);

    // cs_sel beyond NumCs: no select, bytes still clock out
    setup(32'h0001_0300, 2'b11);
    c0 = cs_falls;
    bq.push_back('{d: 8'hC3, dc: 1'b0});
    bus(1'b1, 32'h0, 32'h2C3, 1'b0, 1'b0, 32'h0);
    wait_irq(200);
    chk("NOCS_ASSERTS", cs_falls - c0, 0);
    chk("NOCS_LAST_BYTE", last_rx, 8'hC3);

    // reset in the middle of a byte
    setup(32'h0001_0003, 2'b10);
    bq.push_back('{d: 8'hFF, dc: 1'b0});
    bus(1'b1, 32'h0, 32'h2FF, 1'b0, 1'b0, 32'h0);
    n = 0;
    while (edges != 4 && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    if (edges != 4) fail("EDGE4_TIMEOUT");
    @(posedge clk); #1 rst = 1'b1;
    bq.delete();
    @(posedge clk);
    @(negedge clk);
    chk("MIDRST_CS", cs_no, 2'b11);
    chk("MIDRST_SCK", sck_o, 0);
    chk("MIDRST_MOSI", mosi_o, 0);
    chk("MIDRST_DC", dc_o, 0);
    @(posedge clk); #1 rst = 1'b0;
    bus(1'b0, 32'h8, 32'h0, 1'b0, 1'b0, 32'h100);
    bus(1'b0, 32'h4, 32'h0, 1'b1, 1'b0, 32'h0);
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    fail("GLOBAL_TIMEOUT");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/obi_spi_master_mc.md
OBI_SPI_MASTER_MC -- requirements
Module: obi_spi_master_mc

Interface
REQ-001 SHALL have parameter NumCs, default 2, meaning number of active-low chip selects (1..8).
REQ-002 SHALL have parameter FifoDepth, default 8, meaning TX FIFO entries (power of two, 2..64).
REQ-003 SHALL have parameter IdWidth, default 1, meaning OBI aid/rid width.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 SHALL have ports, one per line (name, direction, width, meaning):
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- req_i  in  1  OBI request.
- we_i  in  1  write enable.
- be_i  in  4  byte enables (ignored).
- addr_i  in  32  byte address; only [3:2] decoded.
- wdata_i  in  32  write data.
- aid_i  in  IdWidth  transaction id.
- gnt_o  out  1  grant.
- rvalid_o  out  1  response valid.
- rdata_o  out  32  read data.
- rid_o  out  IdWidth  response id.
- err_o  out  1  response error.
- sck_o  out  1  SPI clock.
- mosi_o  out  1  SPI data out, MSB first.
- cs_no  out  NumCs  chip selects, active low.
- dc_o  out  1  OLED data/command.
- irq_o  out  1  one-cycle pulse: FIFO drained and engine idle.

Function
REQ-006 SHALL assert gnt_o combinationally equal to req_i (no backpressure).
REQ-007 SHALL assert rvalid_o exactly one cycle after each granted request, with rid_o = registered aid_i.
REQ-008 SHALL decode addr_i[3:2]: 0 TXDATA (W), 1 CTRL (R/W), 2 STATUS (R), 3 invalid.
REQ-009 SHALL, on TXDATA write, push {wdata_i[9] (release CS after byte), wdata_i[8] (dc), wdata_i[7:0]}; read of TXDATA returns 0, err 0.
REQ-010 SHALL, on TXDATA write while FIFO full, drop the data and return err_o=1.
REQ-011 SHALL hold CTRL = {div[7:0] bits[7:0], cs_sel bits[10:8], cpol bit 12, cpha bit 13, en bit 16}; reset value 0.
REQ-012 SHALL return STATUS = {level bits[6:0], empty bit 8, full bit 9, busy bit 10}.
REQ-013 SHALL return err_o=1, rdata_o=0 for offset 3 and for STATUS writes; no state change.
REQ-014 SHALL use half-period = div+1 clk cycles.
REQ-015 SHALL run FSM IDLE -> LEAD -> XFER -> TRAIL -> (LEAD-skip to XFER | IDLE).
REQ-016 SHALL leave IDLE only when en=1 and FIFO non-empty; pop entry, latch dc_o, drive cs_no[cs_sel]=0, stay one half-period in LEAD.
REQ-017 SHALL in XFER toggle sck_o every half-period, 16 toggles per byte; cpha=0 drives mosi_o before first edge, cpha=1 drives on first edge.
REQ-018 SHALL in TRAIL wait one half-period; if release bit=0 and FIFO non-empty, pop and re-enter XFER keeping CS low; else deassert all cs_no, go IDLE.
REQ-019 SHALL, if release bit=0 and FIFO empty at TRAIL end, keep CS low and wait in TRAIL until push or en=0.
REQ-020 SHALL ignore CTRL changes to cs_sel/cpol/cpha/div while busy (latched in LEAD); en=0 aborts at next byte boundary.
REQ-021 SHALL drive sck_o=cpol whenever not in XFER.
REQ-022 SHALL treat cs_sel >= NumCs as no CS asserted; bytes still clock out.
REQ-023 SHALL allow push and pop in the same cycle with level unchanged, including when full.
REQ-024 SHALL pulse irq_o one cycle on entering IDLE with FIFO empty.

Reset
REQ-025 SHALL reset: FIFO empty, FSM IDLE, CTRL=0, sck_o=0, mosi_o=0, cs_no all 1, dc_o=0, irq_o=0, rvalid_o=0, err_o=0.
REQ-026 SHALL abort any transfer on rst_i mid-byte, with outputs at reset values the following cycle.

Verification
REQ-027 CTRL=0x10003 (div=3, cs0, mode0), write TXDATA 0xA5 -> cs_no[0] low, 8 sck rising edges at 8-clk period, mosi 1,0,1,0,0,1,0,1, CS high, irq_o pulse.
REQ-028 Nine TXDATA writes with FifoDepth=8, en=0 -> ninth returns err_o=1, STATUS level=8 full=1.
REQ-029 Two bytes, first with bit9=0 -> CS stays low across both bytes, single CS assertion.
REQ-030 cpol=1 cpha=1, byte 0x3C, dc bit=1 -> sck idles 1, dc_o=1 throughout, data sampled on rising edges reads 0x3C.
REQ-031 rst_i asserted at 4th sck edge -> next cycle cs_no all 1, sck_o=0, STATUS=0x100.
REQ-032 Read offset 0xC with aid=1 -> rvalid next cycle, rid_o=1, err_o=1, rdata_o=0.
